// File: rtl/i2c_reg_target.sv
// I2C target register file: oversamples SCL/SDA on clk_1us, answers at CHIP_ADDR,
// and exposes a write strobe plus a registered debug read port to the host.
module i2c_reg_target #(
   parameter logic [6:0] CHIP_ADDR = 7'h39,
   parameter int         ADDR_BITS = 8,
   parameter int         MIN_PHASE = 4
) (
   input  logic       clk_1us,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       busy,
   output logic       wr_stb,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   input  logic [7:0] dbg_addr,
   output logic [7:0] dbg_data
);

   localparam int DEPTH = 1 << ADDR_BITS;
   localparam int QUAL  = MIN_PHASE / 2;
   localparam int CW    = $clog2(MIN_PHASE + 1);

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ACK_ADDR,
      IGNORE,
      REG_ADDR,
      ACK_REG,
      WR_DATA,
      ACK_WR,
      RD_DATA,
      RD_ACK
   } state_t;

   state_t state, state_nxt;

   logic          scl_s1, scl_s2, scl_d;
   logic          sda_s1, sda_s2, sda_d;
   logic [CW-1:0] scl_hi_cnt;
   logic          scl_rise, scl_fall, scl_settled;
   logic          start_det, stop_det, bus_evt;
   logic [3:0]    bit_cnt;
   logic [7:0]    shift, ptr, rx_byte, rd_byte;
   logic          ninth, rw, byte_done, addr_hit;
   logic          sda_oe_nxt, busy_nxt, wr_fire;
   logic [7:0]    mem [DEPTH];

   function automatic logic in_range(input logic [7:0] a);
      return (a >> ADDR_BITS) == 8'd0;
   endfunction

   // Sync FFs idle high so releasing reset on an idle bus never looks like a START.
   always_ff @(posedge clk_1us) begin
      if (!reset) begin
         {scl_s1, scl_s2, scl_d} <= 3'b111;
         {sda_s1, sda_s2, sda_d} <= 3'b111;
         scl_hi_cnt              <= '0;
      end else begin
         scl_s1 <= scl_in;
         scl_s2 <= scl_s1;
         scl_d  <= scl_s2;
         sda_s1 <= sda_in;
         sda_s2 <= sda_s1;
         sda_d  <= sda_s2;
         if (!scl_s2)
            scl_hi_cnt <= '0;
         else if (scl_hi_cnt != CW'(QUAL))
            scl_hi_cnt <= scl_hi_cnt + CW'(1);
      end
   end

   // SDA may only be read as START/STOP once SCL has been high for a while,
   // so a data change racing an SCL edge through the synchronizers is ignored.
   assign scl_settled = (scl_hi_cnt == CW'(QUAL));
   assign scl_rise    = scl_s2 & ~scl_d;
   assign scl_fall    = ~scl_s2 & scl_d;
   assign start_det   = scl_s2 & scl_settled & sda_d & ~sda_s2;
   assign stop_det    = scl_s2 & scl_settled & ~sda_d & sda_s2;
   assign bus_evt     = start_det | stop_det;

   assign rx_byte   = {shift[6:0], sda_s2};
   assign byte_done = scl_rise && (bit_cnt == 4'd7);
   assign addr_hit  = (rx_byte[7:1] == CHIP_ADDR);
   assign rd_byte   = in_range(ptr) ? mem[ptr[ADDR_BITS-1:0]] : 8'hFF;

   always_ff @(posedge clk_1us) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (stop_det)
         state_nxt = IDLE;
      else if (start_det)
         state_nxt = ADDR;
      else begin
         case (state)
            ADDR:     if (byte_done) state_nxt = addr_hit ? ACK_ADDR : IGNORE;
            ACK_ADDR: if (scl_fall && ninth) state_nxt = rw ? RD_DATA : REG_ADDR;
            REG_ADDR: if (byte_done) state_nxt = ACK_REG;
            ACK_REG:  if (scl_fall && ninth) state_nxt = WR_DATA;
            WR_DATA:  if (byte_done) state_nxt = ACK_WR;
            ACK_WR:   if (scl_fall && ninth) state_nxt = WR_DATA;
            RD_DATA:  if (scl_fall && (bit_cnt == 4'd8)) state_nxt = RD_ACK;
            RD_ACK: begin
               if (scl_rise && sda_s2)
                  state_nxt = IGNORE;
               else if (scl_fall && ninth)
                  state_nxt = RD_DATA;
            end
            default: state_nxt = state;
         endcase
      end
   end

   // The ack states drive on the first SCL fall and release on the fall after the 9th rise.
   always_comb begin
      sda_oe_nxt = sda_oe;
      busy_nxt   = busy;
      wr_fire    = 1'b0;
      if (bus_evt) begin
         sda_oe_nxt = 1'b0;
         busy_nxt   = 1'b0;
      end else begin
         case (state)
            ADDR: if (byte_done && addr_hit) busy_nxt = 1'b1;
            ACK_ADDR, ACK_REG, ACK_WR: begin
               if (scl_fall) begin
                  if (!ninth)
                     sda_oe_nxt = 1'b1;
                  else if ((state == ACK_ADDR) && rw)
                     sda_oe_nxt = ~rd_byte[7];
                  else
                     sda_oe_nxt = 1'b0;
               end
            end
            WR_DATA: if (byte_done) wr_fire = 1'b1;
            RD_DATA: if (scl_fall) sda_oe_nxt = (bit_cnt == 4'd8) ? 1'b0 : ~shift[6];
            RD_ACK:  if (scl_fall && ninth) sda_oe_nxt = ~rd_byte[7];
            default: sda_oe_nxt = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_1us) begin
      if (!reset) begin
         sda_oe  <= 1'b0;
         busy    <= 1'b0;
         wr_stb  <= 1'b0;
         wr_addr <= 8'h00;
         wr_data <= 8'h00;
      end else begin
         sda_oe <= sda_oe_nxt;
         busy   <= busy_nxt;
         wr_stb <= wr_fire;
         if (wr_fire) begin
            wr_addr <= ptr;
            wr_data <= rx_byte;
         end
      end
   end

   // The pointer advances after every byte moved in either direction, so it
   // already names the next byte when a read is acked or a new read begins.
   always_ff @(posedge clk_1us) begin
      if (!reset) begin
         bit_cnt <= 4'd0;
         shift   <= 8'h00;
         ptr     <= 8'h00;
         ninth   <= 1'b0;
         rw      <= 1'b0;
      end else begin
         if (bus_evt || (state_nxt != state)) begin
            bit_cnt <= 4'd0;
            ninth   <= 1'b0;
         end else if (scl_rise) begin
            if (state inside {ADDR, REG_ADDR, WR_DATA, RD_DATA})
               bit_cnt <= bit_cnt + 4'd1;
            if (state inside {ACK_ADDR, ACK_REG, ACK_WR, RD_ACK})
               ninth <= 1'b1;
         end
         if (!bus_evt) begin
            case (state)
               ADDR: begin
                  if (scl_rise) shift <= rx_byte;
                  if (byte_done) rw <= sda_s2;
               end
               REG_ADDR: begin
                  if (scl_rise) shift <= rx_byte;
                  if (byte_done) ptr <= rx_byte;
               end
               WR_DATA: begin
                  if (scl_rise) shift <= rx_byte;
                  if (byte_done) ptr <= ptr + 8'd1;
               end
               ACK_ADDR: if (scl_fall && ninth && rw) shift <= rd_byte;
               RD_DATA: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8)
                        ptr <= ptr + 8'd1;
                     else
                        shift <= {shift[6:0], 1'b0};
                  end
               end
               RD_ACK: if (scl_fall && ninth) shift <= rd_byte;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_1us) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= 8'h00;
      end else if (wr_fire && in_range(ptr)) begin
         mem[ptr[ADDR_BITS-1:0]] <= rx_byte;
      end
   end

   // Reads the array before this cycle's write lands, so a colliding write shows up next cycle.
   always_ff @(posedge clk_1us) begin
      if (!reset)
         dbg_data <= 8'h00;
      else
         dbg_data <= in_range(dbg_addr) ? mem[dbg_addr[ADDR_BITS-1:0]] : 8'hFF;
   end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: a bit-banged 100 kHz master on an open-drain
// SDA line, with per-scenario tasks checking acks, strobes, read data and debug reads.
`timescale 1ns/1ps
module tb_i2c_reg_target;

   logic       clk_1us;
   logic       reset;
   logic       scl;
   logic       sda_m;
   logic       sda_line;
   logic       sda_oe;
   logic       busy;
   logic       wr_stb;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] dbg_addr;
   logic [7:0] dbg_data;

   int n_cmp = 0;
   int n_bad = 0;
   int oe_cycles = 0;
   logic [7:0] stb_addr[$];
   logic [7:0] stb_data[$];

   assign sda_line = sda_m & ~sda_oe;

   i2c_reg_target dut (
      .clk_1us (clk_1us),
      .reset   (reset),
      .scl_in  (scl),
      .sda_in  (sda_line),
      .sda_oe  (sda_oe),
      .busy    (busy),
      .wr_stb  (wr_stb),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .dbg_addr(dbg_addr),
      .dbg_data(dbg_data)
   );

   initial clk_1us = 1'b0;
   always #500 clk_1us = ~clk_1us;

   // Strobe log and SDA-drive activity, sampled on the idle clock edge.
   always @(negedge clk_1us) begin
      if (wr_stb === 1'b1) begin
         stb_addr.push_back(wr_addr);
         stb_data.push_back(wr_data);
      end
      if (sda_oe === 1'b1) oe_cycles++;
   end

   initial begin
      #20_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached (got hang, expected finish)");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_1us);
   endtask

   task automatic clock_bit(input logic b, output logic line, output logic oe);
      tick(2);
      sda_m = b;
      tick(3);
      scl = 1'b1;
      tick(3);
      line = sda_line;
      oe   = sda_oe;
      tick(2);
      scl = 1'b0;
   endtask

   task automatic i2c_start();
      tick(2);
      sda_m = 1'b1;
      tick(3);
      scl = 1'b1;
      tick(5);
      sda_m = 1'b0;
      tick(5);
      scl = 1'b0;
   endtask

   task automatic i2c_stop();
      tick(2);
      sda_m = 1'b0;
      tick(3);
      scl = 1'b1;
      tick(5);
      sda_m = 1'b1;
      tick(8);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic acked);
      logic l, o;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], l, o);
      clock_bit(1'b1, l, o);
      acked = o;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d, output logic oe_ack);
      logic l, o;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, l, o);
         d[i] = l;
      end
      clock_bit(~mack, l, o);
      oe_ack = o;
   endtask

   task automatic test_reset();
      reset = 1'b0; scl = 1'b1; sda_m = 1'b1; dbg_addr = 8'h05;
      tick(4);
      n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_sda_oe: got %b expected 0", sda_oe); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (wr_stb !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_wr_stb: got %b expected 0", wr_stb); end
      n_cmp++; if (wr_addr !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_wr_addr: got %h expected 00", wr_addr); end
      n_cmp++; if (wr_data !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_wr_data: got %h expected 00", wr_data); end
      n_cmp++; if (dbg_data !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_dbg_data: got %h expected 00", dbg_data); end
      reset = 1'b1;
      tick(6);
   endtask

   task automatic test_single_write();
      logic a0, a1, a2;
      stb_addr.delete(); stb_data.delete();
      i2c_start();
      write_byte(8'h72, a0);
      write_byte(8'h05, a1);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL sw_busy: got %b expected 1", busy); end
      write_byte(8'hA5, a2);
      i2c_stop();
      n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_bad++; $display("[TB] FAIL sw_acks: got %b expected 111", {a0, a1, a2}); end
      n_cmp++; if (stb_addr.size() != 1) begin n_bad++; $display("[TB] FAIL sw_stb_count: got %0d expected 1", stb_addr.size()); end
      else begin
         n_cmp++; if ({stb_addr[0], stb_data[0]} !== 16'h05A5) begin n_bad++; $display("[TB] FAIL sw_stb: got %h/%h expected 05/a5", stb_addr[0], stb_data[0]); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL sw_busy_stop: got %b expected 0", busy); end
      dbg_addr = 8'h05; tick(2);
      n_cmp++; if (dbg_data !== 8'hA5) begin n_bad++; $display("[TB] FAIL sw_dbg: got %h expected a5", dbg_data); end
   endtask

   task automatic test_burst_wrap();
      logic [7:0] exp_a[3] = '{8'hFE, 8'hFF, 8'h00};
      logic [7:0] exp_d[3] = '{8'h11, 8'h22, 8'h33};
      logic [5:0] acks;
      stb_addr.delete(); stb_data.delete();
      i2c_start();
      write_byte(8'h72, acks[5]);
      write_byte(8'hFE, acks[4]);
      write_byte(8'h11, acks[3]);
      write_byte(8'h22, acks[2]);
      write_byte(8'h33, acks[1]);
      acks[0] = 1'b1;
      i2c_stop();
      n_cmp++; if (acks !== 6'b111111) begin n_bad++; $display("[TB] FAIL bw_acks: got %b expected 111111", acks); end
      n_cmp++; if (stb_addr.size() != 3) begin n_bad++; $display("[TB] FAIL bw_stb_count: got %0d expected 3", stb_addr.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({stb_addr[i], stb_data[i]} !== {exp_a[i], exp_d[i]}) begin
               n_bad++; $display("[TB] FAIL bw_stb%0d: got %h/%h expected %h/%h", i, stb_addr[i], stb_data[i], exp_a[i], exp_d[i]);
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         dbg_addr = exp_a[i]; tick(2);
         n_cmp++; if (dbg_data !== exp_d[i]) begin n_bad++; $display("[TB] FAIL bw_dbg_%h: got %h expected %h", exp_a[i], dbg_data, exp_d[i]); end
      end
   endtask

   task automatic test_combined_read();
      logic a0, a1, a2, a3, a4, oe_nack;
      logic [7:0] d;
      i2c_start();
      write_byte(8'h72, a0);
      write_byte(8'h42, a1);
      write_byte(8'h5C, a2);
      i2c_stop();
      i2c_start();
      write_byte(8'h72, a3);
      write_byte(8'h42, a4);
      n_cmp++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin n_bad++; $display("[TB] FAIL cr_acks: got %b expected 11111", {a0, a1, a2, a3, a4}); end
      i2c_start();
      write_byte(8'h73, a0);
      n_cmp++; if (a0 !== 1'b1) begin n_bad++; $display("[TB] FAIL cr_rd_ack: got %b expected 1", a0); end
      read_byte(1'b0, d, oe_nack);
      n_cmp++; if (d !== 8'h5C) begin n_bad++; $display("[TB] FAIL cr_data: got %h expected 5c", d); end
      n_cmp++; if (oe_nack !== 1'b0) begin n_bad++; $display("[TB] FAIL cr_nack_oe: got %b expected 0", oe_nack); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL cr_busy: got %b expected 1", busy); end
      i2c_stop();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL cr_busy_stop: got %b expected 0", busy); end
   endtask

   task automatic test_multi_read();
      logic [4:0] acks;
      logic a5, oe1, oe2, oe3;
      logic [7:0] d0, d1, d2;
      i2c_start();
      write_byte(8'h72, acks[4]);
      write_byte(8'h10, acks[3]);
      write_byte(8'h81, acks[2]);
      write_byte(8'h7E, acks[1]);
      write_byte(8'h3C, acks[0]);
      i2c_stop();
      i2c_start();
      write_byte(8'h72, a5);
      write_byte(8'h10, oe1);
      i2c_start();
      write_byte(8'h73, oe2);
      n_cmp++; if ({acks, a5, oe1, oe2} !== 8'hFF) begin n_bad++; $display("[TB] FAIL mr_acks: got %b expected 11111111", {acks, a5, oe1, oe2}); end
      read_byte(1'b1, d0, oe1);
      read_byte(1'b0, d1, oe2);
      i2c_stop();
      n_cmp++; if (d0 !== 8'h81) begin n_bad++; $display("[TB] FAIL mr_byte0: got %h expected 81", d0); end
      n_cmp++; if (d1 !== 8'h7E) begin n_bad++; $display("[TB] FAIL mr_byte1: got %h expected 7e", d1); end
      i2c_start();
      write_byte(8'h73, a5);
      read_byte(1'b0, d2, oe3);
      i2c_stop();
      n_cmp++; if (d2 !== 8'h3C) begin n_bad++; $display("[TB] FAIL mr_ptr_persist: got %h expected 3c", d2); end
   endtask

   task automatic test_mismatch();
      logic a0, a1, a2;
      int oe_before;
      stb_addr.delete(); stb_data.delete();
      oe_before = oe_cycles;
      i2c_start();
      write_byte(8'h74, a0);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL mm_busy: got %b expected 0", busy); end
      write_byte(8'h00, a1);
      write_byte(8'hFF, a2);
      i2c_stop();
      n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_bad++; $display("[TB] FAIL mm_acks: got %b expected 000", {a0, a1, a2}); end
      n_cmp++; if (oe_cycles != oe_before) begin n_bad++; $display("[TB] FAIL mm_oe: got %0d driven cycles expected 0", oe_cycles - oe_before); end
      n_cmp++; if (stb_addr.size() != 0) begin n_bad++; $display("[TB] FAIL mm_stb: got %0d expected 0", stb_addr.size()); end
      dbg_addr = 8'h00; tick(2);
      n_cmp++; if (dbg_data !== 8'h33) begin n_bad++; $display("[TB] FAIL mm_dbg: got %h expected 33", dbg_data); end
   endtask

   task automatic test_stop_abort();
      logic a0, a1, a2, l, o;
      logic [7:0] pat = 8'hA0;
      stb_addr.delete(); stb_data.delete();
      i2c_start();
      write_byte(8'h72, a0);
      write_byte(8'h20, a1);
      for (int i = 7; i >= 4; i--) clock_bit(pat[i], l, o);
      i2c_stop();
      n_cmp++; if (stb_addr.size() != 0) begin n_bad++; $display("[TB] FAIL sa_stb: got %0d expected 0", stb_addr.size()); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL sa_busy: got %b expected 0", busy); end
      dbg_addr = 8'h20; tick(2);
      n_cmp++; if (dbg_data !== 8'h00) begin n_bad++; $display("[TB] FAIL sa_dbg: got %h expected 00", dbg_data); end
      i2c_start();
      write_byte(8'h72, a0);
      write_byte(8'h21, a1);
      write_byte(8'hAB, a2);
      i2c_stop();
      n_cmp++; if (stb_addr.size() != 1) begin n_bad++; $display("[TB] FAIL sa_recover_count: got %0d expected 1", stb_addr.size()); end
      else begin
         n_cmp++; if ({stb_addr[0], stb_data[0]} !== 16'h21AB) begin n_bad++; $display("[TB] FAIL sa_recover: got %h/%h expected 21/ab", stb_addr[0], stb_data[0]); end
      end
   endtask

   task automatic test_reset_mid_read();
      logic a0, a1, a2, oe_nack;
      logic [7:0] d;
      int oe_before;
      i2c_start();
      write_byte(8'h72, a0);
      write_byte(8'h30, a1);
      i2c_start();
      write_byte(8'h73, a2);
      tick(4);
      n_cmp++; if (sda_oe !== 1'b1) begin n_bad++; $display("[TB] FAIL rr_drive_msb: got %b expected 1", sda_oe); end
      reset = 1'b0;
      @(posedge clk_1us); #1;
      n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("[TB] FAIL rr_oe_release: got %b expected 0", sda_oe); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rr_busy: got %b expected 0", busy); end
      tick(3);
      reset = 1'b1;
      oe_before = oe_cycles;
      read_byte(1'b0, d, oe_nack);
      i2c_stop();
      n_cmp++; if (d !== 8'hFF) begin n_bad++; $display("[TB] FAIL rr_tail_ignored: got %h expected ff", d); end
      n_cmp++; if (oe_cycles != oe_before) begin n_bad++; $display("[TB] FAIL rr_tail_oe: got %0d driven cycles expected 0", oe_cycles - oe_before); end
      dbg_addr = 8'h05; tick(2);
      n_cmp++; if (dbg_data !== 8'h00) begin n_bad++; $display("[TB] FAIL rr_file_cleared: got %h expected 00", dbg_data); end
   endtask

   initial begin
      $display("[TB] i2c_reg_target directed bench starting");
      test_reset();
      test_single_write();
      test_burst_wrap();
      test_combined_read();
      test_multi_read();
      test_mismatch();
      test_stop_abort();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
